// File: rtl/mem_wait_unit.sv
// Unified instruction/data memory with a fixed-latency wait-state handshake for the multicycle core.
// Optional MEM_ALIGN_CHECK_EN adds the misalign port and suppresses misaligned accesses.
module mem_wait_unit #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ior_d,
    input  logic [31:0]       pc,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       wdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic [31:0]       rdata,
    output logic              mem_ready,
    output logic              mem_busy
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [31:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic [31:0]       addr_sel;
    logic              unused_addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic bad_q, bad_d;
    logic mis_q, mis_d;
    assign misalign    = mis_q;
    assign unused_addr = ^addr_sel[31:ADDR_W+2];
`else
    assign unused_addr = ^{addr_sel[31:ADDR_W+2], addr_sel[1:0]};
`endif

    assign addr_sel  = ior_d ? alu_out : pc;
    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;

    // Next-state, access latching and array write-port selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
`ifdef MEM_ALIGN_CHECK_EN
        bad_d     = bad_q;
        mis_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    mem_we = 1'b1;
                end else if (mem_read || mem_write) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = addr_sel[ADDR_W+1:2];
                    wdata_d = wdata;
                    is_wr_d = mem_write;
                    busy_d  = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    bad_d   = |addr_sel[1:0];
`endif
                end
            end
            S_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    if (bad_q) begin
                        rdata_d = '0;
                        mis_d   = 1'b1;
                    end else
`endif
                    if (is_wr_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx_q;
                        mem_wdata = wdata_q;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            bad_q   <= 1'b0;
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef MEM_ALIGN_CHECK_EN
            bad_q   <= bad_d;
            mis_q   <= mis_d;
`endif
        end
    end

    // Single array write port; reset at the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
